// File: rtl/if_inst_fifo_pkg.sv
// if_inst_fifo_pkg: shared definitions for the instruction fetch buffer.
//   INST_NOP     - instruction word placed in an exception entry
//   EXC_W        - exception code width
//   ENTRY_W      - width of one queued single-instruction entry
//   *_LSB        - bit offsets of the entry fields inside ENTRY_W
//   fifo_entry_t - packed entry {pc, inst, excp, exception, badv}
package if_inst_fifo_pkg;

  localparam int EXC_W   = 7;
  localparam int ENTRY_W = 32 + 32 + 1 + EXC_W + 32;

  localparam int BADV_LSB = 0;
  localparam int EXC_LSB  = 32;
  localparam int EXCP_BIT = 32 + EXC_W;
  localparam int INST_LSB = EXCP_BIT + 1;
  localparam int PC_LSB   = INST_LSB + 32;

  // andi r0, r0, 0
  localparam logic [31:0] INST_NOP = 32'h0340_0000;

  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      inst;
    logic             excp;
    logic [EXC_W-1:0] exception;
    logic [31:0]      badv;
  } fifo_entry_t;

  function automatic fifo_entry_t make_entry(
    input logic [31:0]      pc,
    input logic [31:0]      inst,
    input logic             excp,
    input logic [EXC_W-1:0] exception,
    input logic [31:0]      badv
  );
    fifo_entry_t e;
    e.pc        = pc;
    e.inst      = inst;
    e.excp      = excp;
    e.exception = exception;
    e.badv      = badv;
    return e;
  endfunction

endpackage

// File: rtl/if_fifo_ram.sv
// if_fifo_ram: DEPTH x ENTRY_W register array for the fetch buffer.
//   clk, rstn        - clock, asynchronous active-low reset (clears all entries)
//   we0/waddr0/wdata0 - write port 0 (entry at tail)
//   we1/waddr1/wdata1 - write port 1 (entry at tail+1)
//   raddr0/rdata0    - asynchronous read port 0 (head)
//   raddr1/rdata1    - asynchronous read port 1 (head+1)
module if_fifo_ram
  import if_inst_fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             we0,
  input  logic [PTR_W-1:0] waddr0,
  input  fifo_entry_t      wdata0,
  input  logic             we1,
  input  logic [PTR_W-1:0] waddr1,
  input  fifo_entry_t      wdata1,
  input  logic [PTR_W-1:0] raddr0,
  input  logic [PTR_W-1:0] raddr1,
  output fifo_entry_t      rdata0,
  output fifo_entry_t      rdata1
);

  fifo_entry_t mem [DEPTH];

  // Entries are cleared on reset so the combinational outputs read as zero
  // until something is written. waddr0 and waddr1 are always distinct.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (we0) mem[waddr0] <= wdata0;
      if (we1) mem[waddr1] <= wdata1;
    end
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/if_inst_fifo.sv
// if_inst_fifo: instruction fetch buffer between IF1 and decode.
// Splits each fetch packet into single-instruction entries, queues them in
// order and presents the two oldest entries to decode each cycle.
//   clk, rstn              - clock, asynchronous active-low reset
//   flush                  - discard all queued entries (redirect)
//   in_valid/in_ready      - fetch packet handshake
//   in_pc, in_inst0/1      - packet PC and the two words of its 8-byte block
//   in_excp_flag, in_exception, in_badv - fetch exception info
//   out_valid0/1, out_pc0/1, out_inst0/1, out_excp0/1,
//   out_exception0/1, out_badv0/1 - two decode slots (slot 0 is oldest)
//   out_ready              - decode consumes every valid slot this cycle
module if_inst_fifo
  import if_inst_fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_inst0,
  input  logic [31:0]      in_inst1,
  input  logic             in_excp_flag,
  input  logic [EXC_W-1:0] in_exception,
  input  logic [31:0]      in_badv,
  output logic             out_valid0,
  output logic             out_valid1,
  output logic [31:0]      out_pc0,
  output logic [31:0]      out_pc1,
  output logic [31:0]      out_inst0,
  output logic [31:0]      out_inst1,
  output logic             out_excp0,
  output logic             out_excp1,
  output logic [EXC_W-1:0] out_exception0,
  output logic [EXC_W-1:0] out_exception1,
  output logic [31:0]      out_badv0,
  output logic [31:0]      out_badv1,
  input  logic             out_ready
);

  localparam logic [PTR_W:0] CNT_READY_MAX = (PTR_W+1)'(DEPTH - 2);
  localparam logic [PTR_W:0] CNT_TWO       = (PTR_W+1)'(2);

  logic [PTR_W-1:0] head_q, tail_q;
  logic [PTR_W:0]   count_q;

  logic             push_fire;
  logic [1:0]       push_n, pop_n;
  fifo_entry_t      wr0, wr1, rd0, rd1;

  // Room for a full pair is required even for single-entry packets, so
  // in_ready depends only on the registered count.
  assign in_ready  = (count_q <= CNT_READY_MAX);
  assign push_fire = in_valid && in_ready && !flush;

  always_comb begin
    wr0    = make_entry(in_pc, in_inst0, 1'b0, '0, '0);
    wr1    = make_entry(in_pc + 32'd4, in_inst1, 1'b0, '0, '0);
    push_n = 2'd0;
    if (push_fire) begin
      if (in_excp_flag) begin
        wr0    = make_entry(in_pc, INST_NOP, 1'b1, in_exception, in_badv);
        push_n = 2'd1;
      end else if (in_pc[2]) begin
        // Odd-PC fetch: only the upper word of the block is live.
        wr0    = make_entry(in_pc, in_inst1, 1'b0, '0, '0);
        push_n = 2'd1;
      end else begin
        push_n = 2'd2;
      end
    end
  end

  if_fifo_ram #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ram (
    .clk    (clk),
    .rstn   (rstn),
    .we0    (push_n != 2'd0),
    .waddr0 (tail_q),
    .wdata0 (wr0),
    .we1    (push_n == 2'd2),
    .waddr1 (tail_q + PTR_W'(1)),
    .wdata1 (wr1),
    .raddr0 (head_q),
    .raddr1 (head_q + PTR_W'(1)),
    .rdata0 (rd0),
    .rdata1 (rd1)
  );

  // An exception entry always issues alone in slot 0.
  assign out_valid0 = (count_q != '0) && !flush;
  assign out_valid1 = (count_q >= CNT_TWO) && !flush && !rd0.excp;
  assign pop_n      = out_ready ? ({1'b0, out_valid0} + {1'b0, out_valid1}) : 2'd0;

  assign out_pc0        = rd0.pc;
  assign out_inst0      = rd0.inst;
  assign out_excp0      = rd0.excp;
  assign out_exception0 = rd0.exception;
  assign out_badv0      = rd0.badv;
  assign out_pc1        = rd1.pc;
  assign out_inst1      = rd1.inst;
  assign out_excp1      = rd1.excp;
  assign out_exception1 = rd1.exception;
  assign out_badv1      = rd1.badv;

  // Pointer/count update; flush wins over any push or pop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + PTR_W'(pop_n);
      tail_q  <= tail_q + PTR_W'(push_n);
      count_q <= count_q + (PTR_W+1)'(push_n) - (PTR_W+1)'(pop_n);
    end
  end

endmodule

// File: tb/tb_if_inst_fifo.sv
module tb_if_inst_fifo;
  import if_inst_fifo_pkg::*;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rstn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc, in_inst0, in_inst1, in_badv;
  logic        in_excp_flag;
  logic [6:0]  in_exception;
  logic        out_valid0, out_valid1;
  logic [31:0] out_pc0, out_pc1, out_inst0, out_inst1, out_badv0, out_badv1;
  logic        out_excp0, out_excp1;
  logic [6:0]  out_exception0, out_exception1;
  logic        out_ready;

  int checks = 0;
  int errors = 0;
  fifo_entry_t exp_q[$];

  if_inst_fifo #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pc          (in_pc),
    .in_inst0       (in_inst0),
    .in_inst1       (in_inst1),
    .in_excp_flag   (in_excp_flag),
    .in_exception   (in_exception),
    .in_badv        (in_badv),
    .out_valid0     (out_valid0),
    .out_valid1     (out_valid1),
    .out_pc0        (out_pc0),
    .out_pc1        (out_pc1),
    .out_inst0      (out_inst0),
    .out_inst1      (out_inst1),
    .out_excp0      (out_excp0),
    .out_excp1      (out_excp1),
    .out_exception0 (out_exception0),
    .out_exception1 (out_exception1),
    .out_badv0      (out_badv0),
    .out_badv1      (out_badv1),
    .out_ready      (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: on every negedge, each slot decode would consume is
  // compared against the oldest expected entry.
  task automatic monitor_loop();
    fifo_entry_t act, e;
    forever begin
      @(negedge clk);
      if (out_ready && rstn) begin
        if (out_valid0) begin
          act = {out_pc0, out_inst0, out_excp0, out_exception0, out_badv0};
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL slot0_unexpected: got pc %0h expected no entry", out_pc0);
          end else begin
            e = exp_q.pop_front();
            check("slot0_entry", 128'(act), 128'(e));
          end
        end
        if (out_valid1) begin
          act = {out_pc1, out_inst1, out_excp1, out_exception1, out_badv1};
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL slot1_unexpected: got pc %0h expected no entry", out_pc1);
          end else begin
            e = exp_q.pop_front();
            check("slot1_entry", 128'(act), 128'(e));
          end
        end
      end
    end
  endtask

  task automatic expect_pkt(input logic [31:0] pc, input logic [31:0] i0, input logic [31:0] i1,
                            input logic ex, input logic [6:0] code, input logic [31:0] badv);
    if (ex) begin
      exp_q.push_back(fifo_entry_t'({pc, INST_NOP, 1'b1, code, badv}));
    end else if (pc[2]) begin
      exp_q.push_back(fifo_entry_t'({pc, i1, 1'b0, 7'd0, 32'd0}));
    end else begin
      exp_q.push_back(fifo_entry_t'({pc, i0, 1'b0, 7'd0, 32'd0}));
      exp_q.push_back(fifo_entry_t'({pc + 32'd4, i1, 1'b0, 7'd0, 32'd0}));
    end
  endtask

  task automatic set_in(input logic [31:0] pc, input logic [31:0] i0, input logic [31:0] i1,
                        input logic ex, input logic [6:0] code, input logic [31:0] badv);
    in_valid     = 1'b1;
    in_pc        = pc;
    in_inst0     = i0;
    in_inst1     = i1;
    in_excp_flag = ex;
    in_exception = code;
    in_badv      = badv;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push_pkt(input logic [31:0] pc, input logic [31:0] i0, input logic [31:0] i1,
                          input logic ex, input logic [6:0] code, input logic [31:0] badv);
    check("in_ready_before_push", 128'(in_ready), 128'(1));
    set_in(pc, i0, i1, ex, code, badv);
    expect_pkt(pc, i0, i1, ex, code, badv);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check({name, "_drained"}, 128'(exp_q.size()), 128'(0));
    check({name, "_empty_valid0"}, 128'(out_valid0), 128'(0));
  endtask

  initial begin
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_inst0 = '0; in_inst1 = '0; in_excp_flag = 1'b0;
    in_exception = '0; in_badv = '0;
    fork
      monitor_loop();
    join_none

    // Reset state
    #12;
    check("rst_valid0", 128'(out_valid0), 128'(0));
    check("rst_valid1", 128'(out_valid1), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_pc0", 128'(out_pc0), 128'(0));
    check("rst_inst1", 128'(out_inst1), 128'(0));
    check("rst_badv0", 128'(out_badv0), 128'(0));
    #1 rstn = 1'b1;
    @(posedge clk); #1;

    // Aligned pair, consumed immediately
    out_ready = 1'b1;
    push_pkt(32'h1c00_0000, 32'hAAAA_0001, 32'hBBBB_0002, 1'b0, 7'h00, 32'h0);
    check("pair_valid0", 128'(out_valid0), 128'(1));
    check("pair_valid1", 128'(out_valid1), 128'(1));
    check("pair_pc1", 128'(out_pc1), 128'(32'h1c00_0004));
    @(posedge clk); #1;
    check("pair_then_empty", 128'(out_valid0), 128'(0));

    // Odd PC: only inst1 queued
    push_pkt(32'h1c00_0004, 32'h1111_1111, 32'h2222_2222, 1'b0, 7'h00, 32'h0);
    check("odd_valid0", 128'(out_valid0), 128'(1));
    check("odd_valid1", 128'(out_valid1), 128'(0));
    check("odd_inst0", 128'(out_inst0), 128'(32'h2222_2222));
    drain("odd");

    // Exception packet then a normal pair
    push_pkt(32'h1c00_0010, 32'h3333_3333, 32'h4444_4444, 1'b1, 7'h08, 32'h1c00_0010);
    check("exc_valid0", 128'(out_valid0), 128'(1));
    check("exc_excp0", 128'(out_excp0), 128'(1));
    check("exc_valid1", 128'(out_valid1), 128'(0));
    check("exc_code0", 128'(out_exception0), 128'(7'h08));
    check("exc_inst0_nop", 128'(out_inst0), 128'(32'h0340_0000));
    push_pkt(32'h1c00_0018, 32'h5555_0005, 32'h6666_0006, 1'b0, 7'h00, 32'h0);
    check("after_exc_valid1", 128'(out_valid1), 128'(1));
    check("after_exc_pc0", 128'(out_pc0), 128'(32'h1c00_0018));
    check("after_exc_excp0", 128'(out_excp0), 128'(0));
    drain("exc");

    // Fill to DEPTH with decode stalled, hold a fifth packet, then release
    out_ready = 1'b0;
    push_pkt(32'h1c00_0100, 32'hC000_0000, 32'hC000_0001, 1'b0, 7'h00, 32'h0);
    push_pkt(32'h1c00_0108, 32'hC000_0002, 32'hC000_0003, 1'b0, 7'h00, 32'h0);
    push_pkt(32'h1c00_0110, 32'hC000_0004, 32'hC000_0005, 1'b0, 7'h00, 32'h0);
    push_pkt(32'h1c00_0118, 32'hC000_0006, 32'hC000_0007, 1'b0, 7'h00, 32'h0);
    check("full_in_ready", 128'(in_ready), 128'(0));
    check("full_pc0", 128'(out_pc0), 128'(32'h1c00_0100));
    set_in(32'h1c00_0120, 32'hC000_0008, 32'hC000_0009, 1'b0, 7'h00, 32'h0);
    expect_pkt(32'h1c00_0120, 32'hC000_0008, 32'hC000_0009, 1'b0, 7'h00, 32'h0);
    @(posedge clk); #1;
    check("held_in_ready", 128'(in_ready), 128'(0));
    check("held_pc0", 128'(out_pc0), 128'(32'h1c00_0100));
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", 128'(in_ready), 128'(1));
    check("release_pc0", 128'(out_pc0), 128'(32'h1c00_0108));
    check("release_pc1", 128'(out_pc1), 128'(32'h1c00_010c));
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain("full");

    // Flush with a same-cycle push
    out_ready = 1'b0;
    push_pkt(32'h1c00_0200, 32'hD000_0000, 32'hD000_0001, 1'b0, 7'h00, 32'h0);
    push_pkt(32'h1c00_0208, 32'hD000_0002, 32'hD000_0003, 1'b0, 7'h00, 32'h0);
    push_pkt(32'h1c00_0214, 32'hD000_0004, 32'hD000_0005, 1'b0, 7'h00, 32'h0);
    check("pre_flush_pc0", 128'(out_pc0), 128'(32'h1c00_0200));
    flush = 1'b1;
    set_in(32'h1c00_0300, 32'hE000_0000, 32'hE000_0001, 1'b0, 7'h00, 32'h0);
    exp_q.delete();
    #1;
    check("flush_valid0", 128'(out_valid0), 128'(0));
    check("flush_valid1", 128'(out_valid1), 128'(0));
    check("flush_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("post_flush_valid0", 128'(out_valid0), 128'(0));
    check("post_flush_in_ready", 128'(in_ready), 128'(1));
    out_ready = 1'b1;
    push_pkt(32'h1c00_0400, 32'hF000_0000, 32'hF000_0001, 1'b0, 7'h00, 32'h0);
    check("post_flush_new_pc0", 128'(out_pc0), 128'(32'h1c00_0400));
    drain("flush");

    // Asynchronous reset mid-cycle with six entries queued
    out_ready = 1'b0;
    push_pkt(32'h1c00_0500, 32'h7000_0000, 32'h7000_0001, 1'b0, 7'h00, 32'h0);
    push_pkt(32'h1c00_0508, 32'h7000_0002, 32'h7000_0003, 1'b0, 7'h00, 32'h0);
    push_pkt(32'h1c00_0510, 32'h7000_0004, 32'h7000_0005, 1'b0, 7'h00, 32'h0);
    check("six_valid1", 128'(out_valid1), 128'(1));
    check("six_in_ready", 128'(in_ready), 128'(1));
    #1 rstn = 1'b0;
    exp_q.delete();
    #1;
    check("async_rst_valid0", 128'(out_valid0), 128'(0));
    check("async_rst_valid1", 128'(out_valid1), 128'(0));
    check("async_rst_in_ready", 128'(in_ready), 128'(1));
    check("async_rst_pc0", 128'(out_pc0), 128'(0));
    #4 rstn = 1'b1;
    @(posedge clk); #1;
    check("after_rst_valid0", 128'(out_valid0), 128'(0));
    check("after_rst_in_ready", 128'(in_ready), 128'(1));
    out_ready = 1'b1;
    push_pkt(32'hFFFF_FFF8, 32'h8000_0000, 32'h8000_0001, 1'b0, 7'h00, 32'h0);
    check("top_pc1", 128'(out_pc1), 128'(32'hFFFF_FFFC));
    drain("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
